// File: rtl/vmem_accum_seq_if.sv
// RAM-side bus of the accumulate-write vector sequencer: two async read ports
// (A/B) and one read-add-write port (C). The sequencer is master, the RAM is slave.
interface vmem_accum_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] vm_addr_a;
  logic [ADDR_W-1:0] vm_addr_b;
  logic [ADDR_W-1:0] vm_addr_c;
  logic [DATA_W-1:0] vm_wd;
  logic              vm_we;
  logic [DATA_W-1:0] vm_rv_a;
  logic [DATA_W-1:0] vm_rv_b;

  modport master (
    output vm_addr_a, vm_addr_b, vm_addr_c, vm_wd, vm_we,
    input  vm_rv_a, vm_rv_b
  );

  modport slave (
    input  vm_addr_a, vm_addr_b, vm_addr_c, vm_wd, vm_we,
    output vm_rv_a, vm_rv_b
  );
endinterface

// File: rtl/vmem_accum_seq.sv
// Vector accumulate sequencer: one element per clock, C[i] += A[i] op B[i].
// Optional VMEM_SEQ_REDUCE_EN adds a `reduce` input that pins the C address at dst.
module vmem_accum_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
`ifdef VMEM_SEQ_REDUCE_EN
  input  logic              reduce,
`endif
  output logic              busy,
  output logic              done,
  vmem_accum_seq_if.master  vm
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic [1:0]        state;
  logic              op_q;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_c;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] offset_c;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= 1'b0;
      base_a <= '0;
      base_b <= '0;
      base_c <= '0;
      len_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            base_a <= src_a & WORD_MASK;
            base_b <= src_b & WORD_MASK;
            base_c <= dst & WORD_MASK;
            len_q  <= len;
            cnt    <= '0;
            state  <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (cnt == len_q - LEN_W'(1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Element i sits at byte offset 4*i; all address sums wrap modulo 2^ADDR_W.
  assign offset = ADDR_W'(cnt) << 2;

`ifdef VMEM_SEQ_REDUCE_EN
  logic reduce_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      reduce_q <= 1'b0;
    end else if (state == IDLE && start) begin
      reduce_q <= reduce;
    end
  end

  assign offset_c = reduce_q ? '0 : offset;
`else
  assign offset_c = offset;
`endif

  assign sum  = vm.vm_rv_a + vm.vm_rv_b;
  assign prod = vm.vm_rv_a * vm.vm_rv_b;

  // The RAM bus is driven only in RUN so the port stays quiet between commands.
  always_comb begin
    vm.vm_addr_a = '0;
    vm.vm_addr_b = '0;
    vm.vm_addr_c = '0;
    vm.vm_wd     = '0;
    vm.vm_we     = 1'b0;
    if (state == RUN) begin
      vm.vm_addr_a = base_a + offset;
      vm.vm_addr_b = base_b + offset;
      vm.vm_addr_c = base_c + offset_c;
      vm.vm_wd     = op_q ? prod : sum;
      vm.vm_we     = 1'b1;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_vmem_accum_seq.sv
// Directed self-checking bench for vmem_accum_seq with a behavioural vector RAM.
// Define VMEM_SEQ_REDUCE_EN to also exercise the reduction mode.
module tb_vmem_accum_seq;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              reduce;
  logic              busy;
  logic              done;

  vmem_accum_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) vm ();

  vmem_accum_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .dst    (dst),
    .len    (len),
`ifdef VMEM_SEQ_REDUCE_EN
    .reduce (reduce),
`endif
    .busy   (busy),
    .done   (done),
    .vm     (vm)
  );

  // Vector RAM: async reads, read-add-write on port C at the clock edge.
  logic [31:0] mem [0:1023];
  logic        preWe;
  logic        clearAll;
  logic [9:0]  preAddr;
  logic [31:0] preData;

  assign vm.vm_rv_a = mem[vm.vm_addr_a[11:2]];
  assign vm.vm_rv_b = mem[vm.vm_addr_b[11:2]];

  always @(posedge clk) begin
    if (clearAll) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (preWe) begin
      mem[preAddr] <= preData;
    end else if (vm.vm_we) begin
      mem[vm.vm_addr_c[11:2]] <= mem[vm.vm_addr_c[11:2]] + vm.vm_wd;
    end
  end

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int weCount;
  int busyCount;
  int doneCount;
  int doneAt;
  int doneAt2;

  logic [31:0] exp4 [4];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    preWe   = 1'b1;
    preAddr = idx[9:0];
    preData = val;
    @(negedge clk);
    preWe   = 1'b0;
  endtask

  // Issue one command and observe obs cycles after the accepting edge.
  task automatic applyStimulus(input logic opIn, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [10:0] n,
                               input logic red, input int obs);
    @(negedge clk);
    op     = opIn;
    src_a  = a;
    src_b  = b;
    dst    = c;
    len    = n;
    reduce = red;
    start  = 1'b1;
    weCount   = 0;
    busyCount = 0;
    doneCount = 0;
    doneAt    = 0;
    for (int k = 1; k <= obs; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (vm.vm_we) weCount++;
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        if (doneAt == 0) doneAt = k;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    src_a    = '0;
    src_b    = '0;
    dst      = '0;
    len      = '0;
    reduce   = 1'b0;
    preWe    = 1'b0;
    preAddr  = '0;
    preData  = '0;
    clearAll = 1'b1;
    repeat (3) @(negedge clk);
    clearAll = 1'b0;

    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_we", vm.vm_we, 0);
    checkOutput("rst_addr_a", vm.vm_addr_a, 0);
    checkOutput("rst_addr_c", vm.vm_addr_c, 0);
    checkOutput("rst_wd", vm.vm_wd, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      preload(i, 32'(i + 1));
      preload(16 + i, 32'(10 * (i + 1)));
    end
    for (int i = 0; i < 3; i++) begin
      preload(256 + i, 32'(i + 1));
      preload(260 + i, 32'(i + 4));
    end

    // Element-wise add into a zeroed C vector.
    applyStimulus(1'b0, 32'h00, 32'h40, 32'h80, 11'd4, 1'b0, 8);
    checkOutput("t1_we_cycles", weCount, 4);
    checkOutput("t1_busy_cycles", busyCount, 5);
    checkOutput("t1_done_pulses", doneCount, 1);
    checkOutput("t1_done_cycle", doneAt, 5);
    exp4 = '{32'd11, 32'd22, 32'd33, 32'd44};
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_c%0d", i), mem[32 + i], exp4[i]);

    // Multiply-accumulate onto C preloaded with ones.
    for (int i = 0; i < 4; i++) preload(32 + i, 32'd1);
    applyStimulus(1'b1, 32'h00, 32'h40, 32'h80, 11'd4, 1'b0, 8);
    checkOutput("t2_we_cycles", weCount, 4);
    exp4 = '{32'd11, 32'd41, 32'd91, 32'd161};
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t2_c%0d", i), mem[32 + i], exp4[i]);

    // Zero-length command goes straight to DONE.
    applyStimulus(1'b0, 32'h00, 32'h40, 32'h80, 11'd0, 1'b0, 4);
    checkOutput("t3_we_cycles", weCount, 0);
    checkOutput("t3_done_cycle", doneAt, 1);
    checkOutput("t3_done_pulses", doneCount, 1);
    checkOutput("t3_busy_cycles", busyCount, 1);
    checkOutput("t3_c0", mem[32], 11);

    // Start held high: mid-run starts ignored, next command latched in IDLE.
    @(negedge clk);
    op    = 1'b0;
    src_a = 32'h00;
    src_b = 32'h40;
    dst   = 32'h100;
    len   = 11'd3;
    start = 1'b1;
    weCount   = 0;
    doneCount = 0;
    doneAt    = 0;
    doneAt2   = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (vm.vm_we) weCount++;
      if (done) begin
        doneCount++;
        if (doneAt == 0) doneAt = k;
        else if (doneAt2 == 0) doneAt2 = k;
      end
      if (k == 1) dst = 32'h200;
      if (k == 6) start = 1'b0;
    end
    checkOutput("t4_we_cycles", weCount, 6);
    checkOutput("t4_done_pulses", doneCount, 2);
    checkOutput("t4_done_first", doneAt, 4);
    checkOutput("t4_done_second", doneAt2, 9);
    checkOutput("t4_c1_0", mem[64], 11);
    checkOutput("t4_c1_2", mem[66], 33);
    checkOutput("t4_c1_3", mem[67], 0);
    checkOutput("t4_c2_0", mem[128], 11);
    checkOutput("t4_c2_2", mem[130], 33);

    // Reset during cycle 2 of an 8-element run.
    @(negedge clk);
    op    = 1'b0;
    src_a = 32'h00;
    src_b = 32'h40;
    dst   = 32'h300;
    len   = 11'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_we", vm.vm_we, 0);
    reset = 1'b0;
    checkOutput("t5_c0", mem[192], 11);
    checkOutput("t5_c1", mem[193], 22);
    checkOutput("t5_c2", mem[194], 0);
    applyStimulus(1'b0, 32'h00, 32'h40, 32'h300, 11'd4, 1'b0, 8);
    checkOutput("t5_done_cycle", doneAt, 5);
    exp4 = '{32'd22, 32'd44, 32'd33, 32'd44};
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t5_c%0d_after", i), mem[192 + i], exp4[i]);
    checkOutput("t5_c4_after", mem[196], 0);

    // Unaligned bases are word-aligned and addresses wrap past the top.
    @(negedge clk);
    op    = 1'b0;
    src_a = 32'hFFFF_FFFE;
    src_b = 32'h41;
    dst   = 32'h602;
    len   = 11'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("wrap_e0_addr_a", vm.vm_addr_a, 32'hFFFF_FFFC);
    checkOutput("wrap_e0_addr_b", vm.vm_addr_b, 32'h40);
    checkOutput("wrap_e0_addr_c", vm.vm_addr_c, 32'h600);
    checkOutput("wrap_e0_wd", vm.vm_wd, 10);
    @(negedge clk);
    checkOutput("wrap_e1_addr_a", vm.vm_addr_a, 0);
    checkOutput("wrap_e1_addr_b", vm.vm_addr_b, 32'h44);
    checkOutput("wrap_e1_addr_c", vm.vm_addr_c, 32'h604);
    checkOutput("wrap_e1_wd", vm.vm_wd, 21);
    @(negedge clk);
    checkOutput("wrap_done", done, 1);
    checkOutput("wrap_done_we", vm.vm_we, 0);
    checkOutput("wrap_done_addr_a", vm.vm_addr_a, 0);
    @(negedge clk);
    checkOutput("wrap_idle_busy", busy, 0);

`ifdef VMEM_SEQ_REDUCE_EN
    // Dot product reduced into a single word.
    applyStimulus(1'b1, 32'h400, 32'h410, 32'h500, 11'd3, 1'b1, 6);
    checkOutput("t6_we_cycles", weCount, 3);
    checkOutput("t6_c0", mem[320], 32);
    checkOutput("t6_c1", mem[321], 0);
    checkOutput("t6_c2", mem[322], 0);
`endif

    // C overlaps A one word ahead: element i+1 reads the value written by element i.
    applyStimulus(1'b0, 32'h400, 32'h410, 32'h404, 11'd2, 1'b0, 5);
    checkOutput("ovl_a0", mem[256], 1);
    checkOutput("ovl_a1", mem[257], 7);
    checkOutput("ovl_a2", mem[258], 15);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
